// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared encodings for the multicycle MIPS main control FSM
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMRD    = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWR    = 4'd5,
      S_RTYPE_EX = 4'd6,
      S_RTYPE_WB = 4'd7,
      S_BRANCH   = 4'd8,
      S_ITYPE_EX = 4'd9,
      S_ITYPE_WB = 4'd10,
      S_JUMP     = 4'd11,
      S_HALT     = 4'd12
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [1:0] ALU_OP_ADD   = 2'b00;
   localparam logic [1:0] ALU_OP_SUB   = 2'b01;
   localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
   localparam logic [1:0] ALU_OP_OPC   = 2'b11;

   localparam logic [1:0] EXT_SIGN = 2'b00;
   localparam logic [1:0] EXT_ZERO = 2'b01;
   localparam logic [1:0] EXT_LUI  = 2'b10;

   localparam logic [1:0] SRCB_B      = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_EXT    = 2'b10;
   localparam logic [1:0] SRCB_EXT_SH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef struct packed {
      logic       pc_en;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
      logic [1:0] ext_op;
      logic       instr_done;
   } ctrl_t;

   // Immediate extension mode implied by an opcode
   function automatic logic [1:0] ext_sel(input logic [5:0] op);
      case (op)
         OP_ANDI, OP_ORI: ext_sel = EXT_ZERO;
         OP_LUI:          ext_sel = EXT_LUI;
         default:         ext_sel = EXT_SIGN;
      endcase
   endfunction

   // True for every opcode the FSM knows how to sequence
   function automatic logic op_known(input logic [5:0] op);
      case (op)
         OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI,
         OP_SLTI, OP_ANDI, OP_ORI, OP_LUI, OP_J: op_known = 1'b1;
         default:                                op_known = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// rtl/mips_ctrl_outdec.sv - Moore control-vector decode from state, opcode and zero (honours ILLEGAL_OP_EN)
module mips_ctrl_outdec
   import mips_ctrl_pkg::*;
(
   input  state_e     state,
   input  logic [5:0] op,
   input  logic       zero,
   output ctrl_t      ctrl
);

   // Per-state datapath controls; handshake gating is applied by the top
   always_comb begin
      ctrl = '0;
      if (state != S_FETCH) begin
         ctrl.ext_op = ext_sel(op);
      end
      case (state)
         S_FETCH: begin
            ctrl.mem_read  = 1'b1;
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.ir_write  = 1'b1;
            ctrl.pc_en     = 1'b1;
         end
         S_DECODE: begin
            ctrl.alu_src_b = SRCB_EXT_SH;
`ifndef ILLEGAL_OP_EN
            ctrl.instr_done = ~op_known(op);
`endif
         end
         S_MEMADR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_EXT;
         end
         S_MEMRD: begin
            ctrl.mem_read = 1'b1;
            ctrl.iord     = 1'b1;
         end
         S_MEMWB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         S_MEMWR: begin
            ctrl.mem_write  = 1'b1;
            ctrl.iord       = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         S_RTYPE_EX: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_B;
            ctrl.alu_op    = ALU_OP_FUNCT;
         end
         S_RTYPE_WB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.reg_dst    = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         S_BRANCH: begin
            ctrl.alu_src_a  = 1'b1;
            ctrl.alu_src_b  = SRCB_B;
            ctrl.alu_op     = ALU_OP_SUB;
            ctrl.pc_source  = PCSRC_ALUOUT;
            ctrl.pc_en      = zero ^ (op == OP_BNE);
            ctrl.instr_done = 1'b1;
         end
         S_ITYPE_EX: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_EXT;
            ctrl.alu_op    = ALU_OP_OPC;
         end
         S_ITYPE_WB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         S_JUMP: begin
            ctrl.pc_source  = PCSRC_JUMP;
            ctrl.pc_en      = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         default: begin
            ctrl.ext_op = EXT_SIGN;
         end
      endcase
   end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multicycle MIPS main control FSM (optional ILLEGAL_OP_EN halt on unknown opcode)
module mips_multicycle_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter int FETCH_TIMEOUT = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_en,
   output logic       iord,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] pc_source,
   output logic [1:0] ext_op,
   output logic [3:0] state,
   output logic       instr_done,
`ifdef ILLEGAL_OP_EN
   output logic       illegal_op,
`endif
   output logic       timeout_err
);

   localparam logic [15:0] TO_LIM = 16'(FETCH_TIMEOUT);

   state_e      state_q, state_d;
   logic [5:0]  opcode_q, opcode_d;
   logic [15:0] cnt_q, cnt_d;
   logic        mem_state;
   logic        expired;
   logic [5:0]  dec_op;
   ctrl_t       dec;

   // funct is consumed by the ALU decoder; the main FSM only sequences on opcode
   logic unused_funct;
   assign unused_funct = ^funct;

   assign mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
   assign expired   = (FETCH_TIMEOUT != 0) && mem_state && (cnt_q == TO_LIM);

`ifdef ILLEGAL_OP_EN
   logic illegal_q, illegal_d;

   // Sticky illegal-opcode flag, only reset clears it
   always_ff @(posedge clk) begin
      if (rst) illegal_q <= 1'b0;
      else     illegal_q <= illegal_d;
   end

   // Set on the decode cycle of an unknown opcode
   always_comb begin
      illegal_d = illegal_q | ((state_q == S_DECODE) && !op_known(opcode));
   end

   assign illegal_op = illegal_q;
`endif

   // State, latched opcode and wait counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_FETCH;
         opcode_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         opcode_q <= opcode_d;
         cnt_q    <= cnt_d;
      end
   end

   // Next-state, opcode latch and per-state wait counter
   always_comb begin
      state_d  = state_q;
      opcode_d = (state_q == S_DECODE) ? opcode : opcode_q;
      case (state_q)
         S_FETCH:  if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_RTYPE:                                 state_d = S_RTYPE_EX;
               OP_LW, OP_SW:                             state_d = S_MEMADR;
               OP_BEQ, OP_BNE:                           state_d = S_BRANCH;
               OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: state_d = S_ITYPE_EX;
               OP_J:                                     state_d = S_JUMP;
`ifdef ILLEGAL_OP_EN
               default:                                  state_d = S_HALT;
`else
               default:                                  state_d = S_FETCH;
`endif
            endcase
         end
         S_MEMADR:   state_d = (opcode_q == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:    if (mem_ready) state_d = S_MEMWB;
         S_MEMWB:    state_d = S_FETCH;
         S_MEMWR:    if (mem_ready) state_d = S_FETCH;
         S_RTYPE_EX: state_d = S_RTYPE_WB;
         S_RTYPE_WB: state_d = S_FETCH;
         S_ITYPE_EX: state_d = S_ITYPE_WB;
         S_ITYPE_WB: state_d = S_FETCH;
         S_BRANCH:   state_d = S_FETCH;
         S_JUMP:     state_d = S_FETCH;
         S_HALT:     state_d = S_HALT;
         default:    state_d = S_FETCH;
      endcase
      if (expired) begin
         state_d = S_FETCH;
      end
      if ((state_d != state_q) || expired) cnt_d = '0;
      else if (cnt_q != 16'hFFFF)          cnt_d = cnt_q + 16'd1;
      else                                 cnt_d = cnt_q;
   end

   // The decode cycle sees the live IR opcode; later states use the latched copy
   assign dec_op = (state_q == S_DECODE) ? opcode : opcode_q;

   mips_ctrl_outdec u_outdec (
      .state (state_q),
      .op    (dec_op),
      .zero  (zero),
      .ctrl  (dec)
   );

   // Outputs: handshake gating in FETCH/MEMWR, writes killed on reset or timeout
   always_comb begin
      logic rdy_gate;
      logic kill;
      rdy_gate    = ((state_q == S_FETCH) || (state_q == S_MEMWR)) ? mem_ready : 1'b1;
      kill        = rst | expired;
      pc_en       = dec.pc_en & rdy_gate & ~kill;
      ir_write    = dec.ir_write & rdy_gate & ~kill;
      instr_done  = dec.instr_done & rdy_gate & ~kill;
      mem_write   = dec.mem_write & ~kill;
      reg_write   = dec.reg_write & ~kill;
      iord        = dec.iord;
      mem_read    = dec.mem_read;
      reg_dst     = dec.reg_dst;
      mem_to_reg  = dec.mem_to_reg;
      alu_src_a   = dec.alu_src_a;
      alu_src_b   = dec.alu_src_b;
      alu_op      = dec.alu_op;
      pc_source   = dec.pc_source;
      ext_op      = dec.ext_op;
      state       = state_q;
      timeout_err = expired;
   end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - scoreboard bench for mips_multicycle_ctrl (ILLEGAL_OP_EN aware)
module tb_mips_multicycle_ctrl;

   localparam int TO = 6;

   typedef struct packed {
      logic [3:0] state;
      logic       ill;
      logic       pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
      logic [1:0] alu_src_b, alu_op, pc_source, ext_op;
      logic       instr_done, timeout_err;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] opcode = '0;
   logic [5:0] funct = '0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
   logic [1:0] alu_src_b, alu_op, pc_source, ext_op;
   logic [3:0] state;
   logic       instr_done, timeout_err;
`ifdef ILLEGAL_OP_EN
   logic       illegal_op;
`endif

   exp_t       q[$];
   exp_t       mon_e;
   int         n_chk = 0;
   int         n_pass = 0;
   int         cyc = 0;
   logic [5:0] cur_op = '0;
   logic       cur_z = 1'b0;
   logic       ill = 1'b0;

   mips_multicycle_ctrl #(.FETCH_TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
      .pc_en(pc_en), .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source), .ext_op(ext_op),
      .state(state), .instr_done(instr_done),
`ifdef ILLEGAL_OP_EN
      .illegal_op(illegal_op),
`endif
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      else n_pass++;
   endtask

   function automatic logic known(input logic [5:0] op);
      case (op)
         6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b001000,
         6'b001010, 6'b001100, 6'b001101, 6'b001111, 6'b000010: known = 1'b1;
         default: known = 1'b0;
      endcase
   endfunction

   // Expected outputs for one cycle, written from the control table
   function automatic exp_t ref_out(input logic [3:0] st, input logic [5:0] op, input logic z,
                                    input logic rdy, input logic r, input logic to);
      exp_t e;
      e = '0;
      e.state = st;
      if (st != 4'd0 && st != 4'd12)
         e.ext_op = (op == 6'b001100 || op == 6'b001101) ? 2'b01 : (op == 6'b001111) ? 2'b10 : 2'b00;
      case (st)
         4'd0:  begin e.mem_read = 1; e.alu_src_b = 2'b01; e.ir_write = rdy; e.pc_en = rdy; end
         4'd1:  begin
            e.alu_src_b = 2'b11;
`ifndef ILLEGAL_OP_EN
            e.instr_done = !known(op);
`endif
         end
         4'd2:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
         4'd3:  begin e.mem_read = 1; e.iord = 1; end
         4'd4:  begin e.reg_write = 1; e.mem_to_reg = 1; e.instr_done = 1; end
         4'd5:  begin e.mem_write = 1; e.iord = 1; e.instr_done = rdy; end
         4'd6:  begin e.alu_src_a = 1; e.alu_op = 2'b10; end
         4'd7:  begin e.reg_write = 1; e.reg_dst = 1; e.instr_done = 1; end
         4'd8:  begin e.alu_src_a = 1; e.alu_op = 2'b01; e.pc_source = 2'b01;
                      e.pc_en = (op == 6'b000101) ? !z : z; e.instr_done = 1; end
         4'd9:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_op = 2'b11; end
         4'd10: begin e.reg_write = 1; e.instr_done = 1; end
         4'd11: begin e.pc_source = 2'b10; e.pc_en = 1; e.instr_done = 1; end
         default: ;
      endcase
      if (r || to) begin
         e.pc_en = 0; e.ir_write = 0; e.mem_write = 0; e.reg_write = 0; e.instr_done = 0;
      end
      e.timeout_err = to;
      return e;
   endfunction

   // Drive one cycle and push what the DUT must show in it
   task automatic run(input logic [3:0] st, input logic rdy, input logic r, input logic to);
      exp_t e;
      @(posedge clk);
      #1;
      mem_ready = rdy; rst = r; zero = cur_z; opcode = cur_op;
      e = ref_out(st, cur_op, cur_z, rdy, r, to);
      e.ill = ill;
      q.push_back(e);
      if (r) ill = 1'b0;
`ifdef ILLEGAL_OP_EN
      else if (st == 4'd1 && !known(cur_op)) ill = 1'b1;
`endif
   endtask

   task automatic run1(input logic [3:0] st);
      run(st, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic instr(input logic [5:0] op, input logic z, input int memwait);
      cur_op = op; cur_z = z;
      run1(0); run1(1);
      case (op)
         6'b100011: begin run1(2); run1(3); run1(4); end
         6'b101011: begin
            run1(2);
            for (int i = 0; i < memwait; i++) run(5, 1'b0, 1'b0, 1'b0);
            run1(5);
         end
         6'b000000: begin run1(6); run1(7); end
         6'b000100, 6'b000101: run1(8);
         6'b001000, 6'b001010, 6'b001100, 6'b001101, 6'b001111: begin run1(9); run1(10); end
         6'b000010: run1(11);
         default: begin
`ifdef ILLEGAL_OP_EN
            run1(12); run(12, 1'b0, 1'b0, 1'b0); run1(12);
            run(12, 1'b1, 1'b1, 1'b0);
`endif
         end
      endcase
   endtask

   // Scoreboard: compare every pushed expectation mid-cycle
   always @(negedge clk) begin
      if (q.size() != 0) begin
         mon_e = q.pop_front();
         chk("state", 32'(state), 32'(mon_e.state));
         chk("ctrl",
             32'({pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
                  alu_src_b, alu_op, pc_source, ext_op, instr_done, timeout_err}),
             32'({mon_e.pc_en, mon_e.iord, mon_e.mem_read, mon_e.mem_write, mon_e.ir_write, mon_e.reg_dst,
                  mon_e.mem_to_reg, mon_e.reg_write, mon_e.alu_src_a, mon_e.alu_src_b, mon_e.alu_op,
                  mon_e.pc_source, mon_e.ext_op, mon_e.instr_done, mon_e.timeout_err}));
`ifdef ILLEGAL_OP_EN
         chk("illegal_op", 32'(illegal_op), 32'(mon_e.ill));
`endif
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      // reset held two cycles, then idle FETCH
      run(0, 1'b0, 1'b1, 1'b0);
      run(0, 1'b0, 1'b0, 1'b0);
      run(0, 1'b0, 1'b0, 1'b0);
      instr(6'b100011, 1'b0, 0);   // lw
      instr(6'b101011, 1'b0, 3);   // sw, 3 wait cycles
      instr(6'b000000, 1'b1, 0);   // R-type
      instr(6'b000100, 1'b1, 0);   // beq taken
      instr(6'b000100, 1'b0, 0);   // beq not taken
      instr(6'b000101, 1'b1, 0);   // bne not taken
      instr(6'b000101, 1'b0, 0);   // bne taken
      instr(6'b001000, 1'b0, 0);   // addi
      instr(6'b001010, 1'b0, 0);   // slti
      instr(6'b001100, 1'b0, 0);   // andi
      instr(6'b001101, 1'b0, 0);   // ori
      instr(6'b001111, 1'b0, 0);   // lui
      instr(6'b000010, 1'b0, 0);   // j
      instr(6'b111111, 1'b0, 0);   // unknown opcode
      instr(6'b001000, 1'b0, 0);   // recovery
      // FETCH timeout: ready arriving on the expiry cycle is ignored
      cur_op = 6'b000000;
      for (int i = 0; i < TO; i++) run(0, 1'b0, 1'b0, 1'b0);
      run(0, 1'b1, 1'b0, 1'b1);
      // MEMWR: longest legal wait, then a timeout
      instr(6'b101011, 1'b0, TO - 1);
      cur_op = 6'b101011;
      run1(0); run1(1); run1(2);
      for (int i = 0; i < TO; i++) run(5, 1'b0, 1'b0, 1'b0);
      run(5, 1'b1, 1'b0, 1'b1);
      // reset in MEMWR with ready high: store must not complete
      run1(0); run1(1); run1(2);
      run(5, 1'b1, 1'b1, 1'b0);
      run(0, 1'b0, 1'b0, 1'b0);
      instr(6'b001111, 1'b0, 0);
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("drain", 32'(q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
